// File: rtl/sdhci_dat_tx_sequencer.sv
// sdhci_dat_tx_sequencer
// Sends one SD write data block on DAT0 in 1-bit mode: start bit, payload
// bytes MSB first, serial CRC16, end bit. It then collects the card's CRC
// status token and waits out card busy before reporting completion.
// Optional build macro: SDHCI_DAT_CRC_INJECT_EN adds crc_inject_i, which
// corrupts bit 0 of the transmitted CRC for the block it is sampled with.
module sdhci_dat_tx_sequencer #(
    parameter int LEN_W          = 12,
    parameter int STATUS_TIMEOUT = 16,
    parameter int BUSY_TIMEOUT   = 65535
) (
    input  logic             sd_clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] block_len_i,
`ifdef SDHCI_DAT_CRC_INJECT_EN
    input  logic             crc_inject_i,
`endif
    input  logic [7:0]       data_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic             sd_dat0_o,
    output logic             sd_dat0_en_o,
    input  logic             sd_dat0_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [2:0]       status_o,
    output logic [2:0]       error_o
);

    // Shared per-state counter: wide enough for the longest timeout and for
    // the 16 CRC cycles.
    localparam int TMAX_C   = (STATUS_TIMEOUT > BUSY_TIMEOUT) ? STATUS_TIMEOUT : BUSY_TIMEOUT;
    localparam int CNT_RAW  = $clog2(TMAX_C + 1);
    localparam int CNT_W    = (CNT_RAW > 5) ? CNT_RAW : 5;

    localparam logic [CNT_W-1:0] CNT_ZERO      = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_NCRC_LAST = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TOK_LAST  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_CRC_LAST  = CNT_W'(15);
    localparam logic [CNT_W-1:0] CNT_STAT_LAST = CNT_W'(STATUS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    localparam logic [2:0] ERR_OK       = 3'd0;
    localparam logic [2:0] ERR_UNDERRUN = 3'd1;
    localparam logic [2:0] ERR_STAT_TO  = 3'd4;
    localparam logic [2:0] ERR_BUSY_TO  = 3'd5;
    localparam logic [2:0] ERR_BAD_LEN  = 3'd6;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_START      = 4'd1,
        ST_DATA       = 4'd2,
        ST_CRC        = 4'd3,
        ST_END        = 4'd4,
        ST_NCRC       = 4'd5,
        ST_TOKEN_WAIT = 4'd6,
        ST_TOKEN      = 4'd7,
        ST_TOKEN_END  = 4'd8,
        ST_BUSY       = 4'd9,
        ST_DONE       = 4'd10
    } state_t;

    // One CRC16 (x^16+x^12+x^5+1) step for a single transmitted bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Map the received CRC status token to an error code.
    function automatic logic [2:0] token_err(input logic [2:0] tok);
        case (tok)
            3'b010:  return 3'd0;
            3'b101:  return 3'd2;
            default: return 3'd3;
        endcase
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [LEN_W-1:0] byte_cnt_r;
    logic [7:0]       shift_r;
    logic [15:0]      crc_r;
    logic [2:0]       status_r;
    logic [2:0]       error_r, error_s;
    logic             dat_s, en_s, ready_s;
    logic             data_bit_s;
    logic             crc_flip_s;

    // Bit 7 of each byte comes straight from data_i in the cycle it is consumed.
    assign data_bit_s = (bit_cnt_r == 3'd0) ? (data_valid_i ? data_i[7] : 1'b1) : shift_r[7];

`ifdef SDHCI_DAT_CRC_INJECT_EN
    logic inject_r;

    // Capture the CRC corruption request together with the block start.
    always_ff @(posedge sd_clk_i or posedge rst_i) begin
        if (rst_i) begin
            inject_r <= 1'b0;
        end else if (state_r == ST_IDLE && start_i) begin
            inject_r <= crc_inject_i;
        end else begin
            inject_r <= inject_r;
        end
    end

    assign crc_flip_s = inject_r & (state_r == ST_CRC) & (cnt_r == CNT_CRC_LAST);
`else
    assign crc_flip_s = 1'b0;
`endif

    // Next-state, error code and DAT0 drive decode.
    always_comb begin
        state_s = state_r;
        error_s = error_r;
        dat_s   = 1'b1;
        en_s    = 1'b0;
        ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    if (block_len_i == {LEN_W{1'b0}}) begin
                        state_s = ST_DONE;
                        error_s = ERR_BAD_LEN;
                    end else begin
                        state_s = ST_START;
                        error_s = ERR_OK;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                en_s    = 1'b1;
                dat_s   = 1'b0;
                state_s = ST_DATA;
            end
            ST_DATA: begin
                en_s  = 1'b1;
                dat_s = data_bit_s;
                if (bit_cnt_r == 3'd0) begin
                    ready_s = data_valid_i;
                    if (!data_valid_i) begin
                        state_s = ST_DONE;
                        error_s = ERR_UNDERRUN;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else if (bit_cnt_r == 3'd7 && byte_cnt_r == LEN_W'(1)) begin
                    state_s = ST_CRC;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_CRC: begin
                en_s  = 1'b1;
                dat_s = crc_r[15] ^ crc_flip_s;
                if (cnt_r == CNT_CRC_LAST) begin
                    state_s = ST_END;
                end else begin
                    state_s = ST_CRC;
                end
            end
            ST_END: begin
                en_s    = 1'b1;
                dat_s   = 1'b1;
                state_s = ST_NCRC;
            end
            ST_NCRC: begin
                if (cnt_r == CNT_NCRC_LAST) begin
                    state_s = ST_TOKEN_WAIT;
                end else begin
                    state_s = ST_NCRC;
                end
            end
            ST_TOKEN_WAIT: begin
                if (!sd_dat0_i) begin
                    state_s = ST_TOKEN;
                end else if (cnt_r == CNT_STAT_LAST) begin
                    state_s = ST_DONE;
                    error_s = ERR_STAT_TO;
                end else begin
                    state_s = ST_TOKEN_WAIT;
                end
            end
            ST_TOKEN: begin
                if (cnt_r == CNT_TOK_LAST) begin
                    state_s = ST_TOKEN_END;
                end else begin
                    state_s = ST_TOKEN;
                end
            end
            ST_TOKEN_END: begin
                state_s = ST_BUSY;
            end
            ST_BUSY: begin
                if (sd_dat0_i) begin
                    state_s = ST_DONE;
                    error_s = token_err(status_r);
                end else if (cnt_r == CNT_BUSY_LAST) begin
                    state_s = ST_DONE;
                    error_s = ERR_BUSY_TO;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and error code registers.
    always_ff @(posedge sd_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            error_r <= ERR_OK;
        end else begin
            state_r <= state_s;
            error_r <= error_s;
        end
    end

    // Per-state counter: restarts on every state change, saturates otherwise.
    always_ff @(posedge sd_clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= CNT_ZERO;
        end else if (state_s != state_r) begin
            cnt_r <= CNT_ZERO;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Payload shifter, bit/byte counters, CRC and status token capture.
    always_ff @(posedge sd_clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= {LEN_W{1'b0}};
            shift_r    <= 8'h00;
            crc_r      <= 16'h0000;
            status_r   <= 3'b000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r <= 3'd0;
                    if (start_i) begin
                        byte_cnt_r <= block_len_i;
                        crc_r      <= 16'h0000;
                        status_r   <= 3'b000;
                    end
                end
                ST_DATA: begin
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    crc_r     <= crc16_step(crc_r, data_bit_s);
                    if (bit_cnt_r == 3'd0) begin
                        shift_r <= {data_i[6:0], 1'b0};
                    end else begin
                        shift_r <= {shift_r[6:0], 1'b0};
                    end
                    if (bit_cnt_r == 3'd7) begin
                        byte_cnt_r <= byte_cnt_r - LEN_W'(1);
                    end
                end
                ST_CRC: begin
                    crc_r <= {crc_r[14:0], 1'b0};
                end
                ST_TOKEN: begin
                    status_r <= {status_r[1:0], sd_dat0_i};
                end
                default: begin
                    bit_cnt_r <= bit_cnt_r;
                end
            endcase
        end
    end

    assign data_ready_o = ready_s;
    assign sd_dat0_o    = dat_s;
    assign sd_dat0_en_o = en_s;
    assign busy_o       = (state_r != ST_IDLE);
    assign done_o       = (state_r == ST_DONE);
    assign status_o     = status_r;
    assign error_o      = error_r;

endmodule

// File: doc/sdhci_dat_tx_sequencer.md
Name: sdhci_dat_tx_sequencer

Overview:
Sequences one SD write data block on DAT0 (1-bit bus mode). It frames the block with a start bit, the data bytes (MSB first) and a serially computed CRC16, then an end bit. It then receives the card's CRC status token and waits out card busy. It sits between the SDHCI buffer FIFO and the sdhci_sd_driver DAT pad signals, and its CRC16 is bit-exact with the driver's calculate_crc16.

Parameters:
LEN_W, 12, width of the block length in bytes; supported lengths are 1..2^LEN_W-1.
STATUS_TIMEOUT, 16, max sd_clk cycles to wait for the status token start bit.
BUSY_TIMEOUT, 65535, max sd_clk cycles DAT0 may stay low in busy.

Ports:
sd_clk_i  in  1  SD clock; all state changes on its rising edge.
rst_i  in  1  asynchronous, active-high reset.
start_i  in  1  one-cycle pulse; starts a block. Ignored unless in IDLE.
block_len_i  in  LEN_W  block length in bytes; sampled with start_i.
data_i  in  8  next payload byte.
data_valid_i  in  1  data_i is valid.
data_ready_o  out  1  the byte on data_i is consumed this cycle.
sd_dat0_o  out  1  DAT0 drive value.
sd_dat0_en_o  out  1  DAT0 output enable.
sd_dat0_i  in  1  sampled DAT0.
busy_o  out  1  high in any state other than IDLE.
done_o  out  1  one-cycle pulse at block completion.
status_o  out  3  captured token {b2,b1,b0}; holds its value until the next start.
error_o  out  3  0 ok, 1 underrun, 2 CRC error token (101), 3 write error (110 or other), 4 status timeout, 5 busy timeout, 6 bad length (0).

Behaviour:
- Reset values: sd_dat0_o=1, sd_dat0_en_o=0, data_ready_o=0, busy_o=0, done_o=0, status_o=0, error_o=0. The FSM goes to IDLE and the CRC register clears.
- States: IDLE, START, DATA, CRC, END, NCRC, TOKEN_WAIT, TOKEN, TOKEN_END, BUSY, DONE.
- IDLE: on start_i, latch the length and clear error_o.
  - If the length is 0, go to DONE with error 6.
  - Otherwise go to START and clear the CRC to 0.
- START: drive en=1, dat=0 for 1 cycle.
- DATA: 8 cycles per byte, sent MSB first.
  - In the cycle that emits bit 7, data_ready_o = data_valid_i and data_i is loaded into the shift register.
  - If data_valid_i=0 at that point, this is an underrun: go to DONE with error 1. Release the line (en=0) in DONE.
  - CRC update per emitted bit b: fb = crc[15]^b; crc = {crc[14:0],0} ^ (fb ? 16'h1021 : 0).
- CRC: 16 cycles, driving crc[15] first. The register shifts left and updates no further.
- END: dat=1, en=1 for 1 cycle.
- NCRC: en=0 for 2 cycles.
- TOKEN_WAIT: wait for sd_dat0_i=0. If STATUS_TIMEOUT cycles pass without it, go to DONE with error 4.
- TOKEN: sample 3 bits, MSB first, into status_o.
- TOKEN_END: 1 cycle. Any bit value is accepted here.
- BUSY: remain while sd_dat0_i=0. A BUSY_TIMEOUT overflow gives error 5.
  - Decode the token on exit: 010 gives 0, 101 gives 2, anything else gives 3.
  - An error token still waits out busy before going to DONE.
- DONE: done_o=1 for 1 cycle, then return to IDLE.
- Latency: the start bit appears on the cycle after start_i. The total drive window is 1+8*len+16+1 cycles.
- start_i while busy_o=1 is ignored, with no effect on state.
- rst_i asserted mid-block: release DAT0 immediately (asynchronous). No done_o pulse is produced.
- Timeout counters saturate and reset on every state entry.

Optional Feature:
SDHCI_DAT_CRC_INJECT_EN:
- When defined, add input crc_inject_i, sampled with start_i. If it is set, the transmitted CRC has bit 0 inverted, so the card returns 101 and the block reports error 2.
- When undefined, the port does not exist and the CRC is always correct.

Test Plan:
- 512 bytes of 0xFF with the card returning token 010 and 4 busy cycles -> CRC bits on DAT0 equal 16'h7FA1; status_o=3'b010; error_o=0; done_o pulses once; total drive window 4114 cycles.
- 1-byte block 0x00 -> DAT0 sequence 0, eight 0s, sixteen 0s (CRC 0x0000), then 1; en=0 from the next cycle.
- 2-byte block {0x00,0x01} -> transmitted CRC 16'h1021 (the driver's calculate_crc16 with 'h1 over 16 bits yields the same).
- data_valid_i dropped before the 3rd byte of a 4-byte block -> error_o=1, en=0, done_o pulses; no CRC bits are emitted.
- Card never drives a start bit -> error_o=4 after 16 cycles in TOKEN_WAIT. Separately, token 101 -> error_o=2 after busy releases.
- rst_i asserted during the CRC phase -> en=0 and busy_o=0 immediately. A following start_i runs a clean 1-byte block with the correct CRC.
